// File: rtl/backing_mem_pkg.sv
// Shared types and defaults for the backing-store responder.
// Holds the FSM state encoding, default parameter values and index-width helper.
// Pure declarations; no logic, no latency, no flow control.
package backing_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int DEF_ADDR_WIDTH  = 32;
  localparam int DEF_DATA_WIDTH  = 32;
  localparam int DEF_DEPTH_WORDS = 1024;
  localparam int DEF_LATENCY     = 4;

  // Word-index width for a given storage depth (at least one bit).
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/backing_mem_array.sv
// Single-port synchronous RAM, DEPTH_WORDS x DATA_WIDTH, write enable.
// Latency: read data registered one cycle after the address; write lands on the edge.
// No flow control: accepts an access every cycle.
module backing_mem_array #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [IDX_W-1:0]      addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH_WORDS];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Storage is deliberately never reset; contents survive a responder reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
    rdata_q <= mem_q[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/backing_mem_responder.sv
// Backing-store responder: one request at a time, answered after a fixed LATENCY.
// Latency: resp_valid rises LATENCY cycles after acceptance; writes commit on acceptance.
// Backpressure: req_ready only in IDLE; a response is held until resp_ready.
// Optional MEM_RANGE_CHECK_EN flags out-of-range/misaligned addresses with resp_err.
module backing_mem_responder
  import backing_mem_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
  parameter int LATENCY     = DEF_LATENCY
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err
);

  localparam int IDX_W = idx_width(DEPTH_WORDS);
  localparam int CNT_W = $clog2(LATENCY + 1);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  wr_q, wr_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic [IDX_W-1:0]      req_idx;
  logic                  req_err;
  logic                  mem_we;
  logic [IDX_W-1:0]      mem_addr;
  logic [DATA_WIDTH-1:0] mem_rdata;

  assign req_idx = req_addr[IDX_W+1:2];

`ifdef MEM_RANGE_CHECK_EN
  // Any set bit above the storage window, or a non-word-aligned byte offset, is an error.
  assign req_err  = (|req_addr[ADDR_WIDTH-1:IDX_W+2]) | (|req_addr[1:0]);
  assign resp_err = err_q & (state_q == RESP);
`else
  // Upper bits and byte offset are ignored so the index wraps.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{req_addr[ADDR_WIDTH-1:IDX_W+2], req_addr[1:0], err_q};
  assign req_err  = 1'b0;
  assign resp_err = 1'b0;
`endif

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;

  // In IDLE the RAM sees the incoming index so LATENCY=1 reads have data in time.
  assign mem_addr = (state_q == IDLE) ? req_idx : idx_q;

  backing_mem_array #(
    .DATA_WIDTH  (DATA_WIDTH),
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (req_wdata),
    .rdata (mem_rdata)
  );

  // Next-state for FSM, latency counter, request latch and response data.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    idx_d   = idx_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    mem_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          wr_d    = req_write;
          idx_d   = req_idx;
          err_d   = req_err;
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = WAIT;
          // Reset wins over a simultaneous acceptance, so it must block the write too.
          mem_we  = req_write & ~req_err & ~reset;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          rdata_d = (wr_q | err_q) ? '0 : mem_rdata;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Register all control state; reset drops any in-flight transaction.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      idx_q   <= idx_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_backing_mem_responder.sv
// Directed bench for backing_mem_responder: default build (LATENCY 4) plus a LATENCY 1 copy.
// Expected values are hand-computed constants; range-check expectations follow MEM_RANGE_CHECK_EN.
// Every comparison goes through chk(); one summary line at the end.
module tb_backing_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_write, resp_ready;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] req_addr, req_wdata, resp_rdata;

  logic        b_req_valid, b_req_write, b_resp_ready;
  logic        b_req_ready, b_resp_valid, b_resp_err;
  logic [31:0] b_req_addr, b_req_wdata, b_resp_rdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  backing_mem_responder #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_WORDS(1024), .LATENCY(4)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  backing_mem_responder #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_WORDS(1024), .LATENCY(1)
  ) dut_l1 (
    .clk(clk), .reset(reset),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
    .resp_rdata(b_resp_rdata), .resp_err(b_resp_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Present a request from a negedge and hold it until the accepting edge; returns #1 after it.
  task automatic a_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
    int g;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    g = 0;
    while (!req_ready && g < 20) begin
      @(negedge clk);
      g++;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // Count edges from acceptance until resp_valid; bounded so a dead DUT shows as a wrong latency.
  task automatic a_wait_resp(output int n);
    n = 0;
    while (!resp_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  // Full transaction with resp_ready high: latency, data, error, then handshake on the next edge.
  task automatic a_xact(input string tag, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata,
                        input logic exp_err);
    int n;
    a_req(wr, addr, wdata);
    a_wait_resp(n);
    chk({tag, "_lat"}, 32'(n), 32'd4);
    chk({tag, "_rdata"}, resp_rdata, exp_rdata);
    chk({tag, "_err"}, {31'd0, resp_err}, {31'd0, exp_err});
    @(posedge clk);
    #1;
    chk({tag, "_done"}, {30'd0, resp_valid, req_ready}, 32'b01);
  endtask

  initial begin
    int n;
    logic seen;
    logic [31:0] b_exp [3];

    reset = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b1;
    b_req_valid = 1'b0; b_req_write = 1'b0; b_req_addr = '0; b_req_wdata = '0;
    b_resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_err", {31'd0, resp_err}, 32'd0);
    reset = 1'b0;

    // Basic write / read / second location / first location untouched.
    a_xact("wr10", 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    a_xact("rd10", 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    a_xact("wr20", 1'b1, 32'h20, 32'hCAFEBABE, 32'h0, 1'b0);
    a_xact("rd20", 1'b0, 32'h20, 32'h0, 32'hCAFEBABE, 1'b0);
    a_xact("rd10b", 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

    // Response stall: output held, no acceptance, a stray write pulse must be ignored.
    resp_ready = 1'b0;
    a_req(1'b0, 32'h20, 32'h0);
    a_wait_resp(n);
    chk("stall_lat", 32'(n), 32'd4);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (i == 1) begin
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h10; req_wdata = 32'h11111111;
      end
      if (i == 2) req_valid = 1'b0;
      chk("stall_hold", {30'd0, resp_valid, req_ready}, 32'b10);
      chk("stall_rdata", resp_rdata, 32'hCAFEBABE);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("stall_release", {30'd0, resp_valid, req_ready}, 32'b01);
    chk("stall_rdata_kept", resp_rdata, 32'hCAFEBABE);
    a_xact("rd10_after_stall", 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

    // Reset while WAITing on a read: no response, committed write survives.
    a_xact("wr30", 1'b1, 32'h30, 32'h12345678, 32'h0, 1'b0);
    a_req(1'b0, 32'h30, 32'h0);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    chk("midrst_state", {30'd0, resp_valid, req_ready}, 32'b01);
    chk("midrst_rdata", resp_rdata, 32'h0);
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1 seen = seen | resp_valid;
    end
    chk("midrst_no_resp", {31'd0, seen}, 32'd0);
    a_xact("rd30", 1'b0, 32'h30, 32'h0, 32'h12345678, 1'b0);

    // Out-of-range write: flagged and dropped with the check, aliased to word 0 without.
    a_xact("wr0", 1'b1, 32'h0, 32'h01020304, 32'h0, 1'b0);
`ifdef MEM_RANGE_CHECK_EN
    a_xact("wr1000", 1'b1, 32'h1000, 32'hAAAA5555, 32'h0, 1'b1);
    a_xact("rd0", 1'b0, 32'h0, 32'h0, 32'h01020304, 1'b0);
    a_xact("rd_misalign", 1'b0, 32'h32, 32'h0, 32'h0, 1'b1);
`else
    a_xact("wr1000", 1'b1, 32'h1000, 32'hAAAA5555, 32'h0, 1'b0);
    a_xact("rd0", 1'b0, 32'h0, 32'h0, 32'hAAAA5555, 1'b0);
    a_xact("rd_misalign", 1'b0, 32'h32, 32'h0, 32'h12345678, 1'b0);
`endif

    // LATENCY=1 copy: requests back to back, each answered one edge after acceptance,
    // and ready again at the first negedge after the handshake edge.
    b_exp[0] = 32'h0;
    b_exp[1] = 32'h00000077;
    b_exp[2] = 32'h00000077;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      b_req_valid = 1'b1;
      b_req_write = (i == 0);
      b_req_addr  = 32'h8;
      b_req_wdata = 32'h00000077;
      chk("l1_ready", {31'd0, b_req_ready}, 32'd1);
      @(posedge clk);
      #1;
      chk("l1_wait", {30'd0, b_resp_valid, b_req_ready}, 32'b00);
      @(posedge clk);
      #1;
      chk("l1_valid", {31'd0, b_resp_valid}, 32'd1);
      chk("l1_rdata", b_resp_rdata, b_exp[i]);
      chk("l1_err", {31'd0, b_resp_err}, 32'd0);
      @(posedge clk);
      #1;
      chk("l1_hs", {31'd0, b_resp_valid}, 32'd0);
    end
    b_req_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
